// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered SEL_W-to-2^SEL_W one-hot decoder with
// enable, hold/load mode and an autonomous scan mode with programmable dwell.
// Optional build macro: DEC_SCAN_GRAY_EN (scan walks lines in Gray-code order).
module onehot_scan_decoder #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DWELL = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    output logic [(2**SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        idx,
    output logic                    busy,
    output logic                    wrap
);

    localparam int unsigned OUT_W  = 2**SEL_W;
    localparam int unsigned DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  POS_LAST  = SEL_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    pos_q, pos_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                wrap_d;
    logic [SEL_W-1:0]    sel_pos;
    logic [SEL_W-1:0]    idx_d;
    logic [OUT_W-1:0]    y_d;
    logic                busy_d;
    logic [SEL_W-1:0]    pos_idx;

`ifdef DEC_SCAN_GRAY_EN
    // Gray-to-binary so that a HOLD load lands on the line whose index equals sel
    function automatic logic [SEL_W-1:0] gray2bin(input logic [SEL_W-1:0] g);
        logic [SEL_W-1:0] b;
        b[SEL_W-1] = g[SEL_W-1];
        for (int i = int'(SEL_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign sel_pos = gray2bin(sel);
    assign pos_idx = pos_d ^ (pos_d >> 1);
`else
    assign sel_pos = sel;
    assign pos_idx = pos_d;
`endif

    // State, position and dwell counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Next state, position, dwell count and wrap event; en overrides everything
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dcnt_d  = dcnt_q;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            pos_d   = '0;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dcnt_d = '0;
                    if (mode) begin
                        state_d = ST_SCAN;
                        pos_d   = '0;
                    end else begin
                        state_d = ST_HOLD;
                        pos_d   = sel_pos;
                    end
                end
                ST_HOLD: begin
                    if (mode) begin
                        state_d = ST_SCAN;
                        dcnt_d  = '0;
                    end else if (load) begin
                        pos_d = sel_pos;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        // Freeze on the current line; a step due now is dropped
                        state_d = ST_HOLD;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DCNT_LAST) begin
                        dcnt_d = '0;
                        pos_d  = pos_q + SEL_W'(1);
                        wrap_d = (pos_q == POS_LAST);
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pos_d   = '0;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    // Output values derived from the next state, registered below
    always_comb begin
        idx_d  = '0;
        y_d    = '0;
        busy_d = 1'b0;
        if (state_d != ST_IDLE) begin
            idx_d = pos_idx;
            y_d   = OUT_W'(1) << idx_d;
        end
        busy_d = (state_d == ST_SCAN);
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y    <= '0;
            idx  <= '0;
            busy <= 1'b0;
            wrap <= 1'b0;
        end else begin
            y    <= y_d;
            idx  <= idx_d;
            busy <= busy_d;
            wrap <= wrap_d;
        end
    end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder (SEL_W=3): vector table for
// hold/load/enable behaviour plus hand sequences for scan, mode switch,
// disable and asynchronous reset.
module tb_onehot_scan_decoder;

    localparam int unsigned SEL_W = 3;
`ifdef DEC_SCAN_GRAY_EN
    localparam int unsigned DWELL = 1;
`else
    localparam int unsigned DWELL = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic       load;
    logic [7:0] y;
    logic [2:0] idx;
    logic       busy;
    logic       wrap;

    int checks = 0;
    int errors = 0;

`ifdef DEC_SCAN_GRAY_EN
    logic [2:0] ord [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
    logic [2:0] ord [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] sel;
        logic       load;
        logic [7:0] ey;
        logic [2:0] eidx;
        logic       eb;
        logic       ew;
    } vec_t;

    vec_t vecs [10];

    onehot_scan_decoder #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .y     (y),
        .idx   (idx),
        .busy  (busy),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] ey, input logic [2:0] eidx,
                         input logic eb, input logic ew);
        checks++;
        if (y !== ey || idx !== eidx || busy !== eb || wrap !== ew) begin
            errors++;
            $display("FAIL %s: got y=%b idx=%0d busy=%b wrap=%b, want y=%b idx=%0d busy=%b wrap=%b",
                     name, y, idx, busy, wrap, ey, eidx, eb, ew);
        end
    endtask

    task automatic drive(input logic e, input logic m, input logic [2:0] s, input logic l);
        @(negedge clk);
        en   = e;
        mode = m;
        sel  = s;
        load = l;
        @(posedge clk);
        #1;
    endtask

    // Scan from IDLE for n cycles, checking every cycle against the line order
    task automatic scan_run(input int n, input string tag);
        int p;
        logic w;
        logic [7:0] ey;
        for (int k = 1; k <= n; k++) begin
            drive(1'b1, 1'b1, 3'd0, 1'b0);
            p  = ((k - 1) / int'(DWELL)) % 8;
            w  = (k > 1) && (((k - 1) % (8 * int'(DWELL))) == 0);
            ey = 8'd1 << ord[p];
            check($sformatf("%s_c%0d", tag, k), ey, ord[p], 1'b1, w);
        end
    endtask

    initial begin
        //              en    mode  sel   load  y         idx   busy  wrap
        vecs[0] = '{1'b1, 1'b0, 3'd5, 1'b0, 8'h20, 3'd5, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 3'd2, 1'b0, 8'h20, 3'd5, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 3'd2, 1'b1, 8'h04, 3'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 3'd7, 1'b0, 8'h04, 3'd2, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 3'd7, 1'b1, 8'h80, 3'd7, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 3'd7, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 3'd5, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 3'd5, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 1'b0;
        sel   = 3'd5;
        load  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].sel, vecs[i].load);
            check($sformatf("vec%0d", i), vecs[i].ey, vecs[i].eidx, vecs[i].eb, vecs[i].ew);
        end

        // Two full scan periods from IDLE
        scan_run(33, "scan");
        drive(1'b0, 1'b1, 3'd0, 1'b0);
        check("scan_off", 8'h00, 3'd0, 1'b0, 1'b0);

`ifndef DEC_SCAN_GRAY_EN
        // Drop mode at idx=6 with dcnt=1: freeze, then resume with full dwell
        scan_run(14, "pre_sw");
        drive(1'b1, 1'b0, 3'd0, 1'b0);
        check("sw_hold", 8'h40, 3'd6, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'd3, 1'b0);
        check("sw_hold2", 8'h40, 3'd6, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'd0, 1'b0);
        check("sw_res0", 8'h40, 3'd6, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 3'd0, 1'b0);
        check("sw_res1", 8'h40, 3'd6, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 3'd0, 1'b0);
        check("sw_res2", 8'h80, 3'd7, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 3'd0, 1'b0);
        check("sw_res3", 8'h80, 3'd7, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 3'd0, 1'b0);
        check("sw_wrap", 8'h01, 3'd0, 1'b1, 1'b1);

        // Disable at idx=3, then re-enable in scan mode
        drive(1'b0, 1'b1, 3'd0, 1'b0);
        scan_run(7, "pre_dis");
        drive(1'b0, 1'b1, 3'd0, 1'b0);
        check("dis", 8'h00, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'd0, 1'b0);
        check("reen", 8'h01, 3'd0, 1'b1, 1'b0);
`else
        // Gray HOLD loads select the line whose index equals sel
        drive(1'b1, 1'b0, 3'd3, 1'b0);
        check("g_hold3", 8'h08, 3'd3, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'd6, 1'b1);
        check("g_load6", 8'h40, 3'd6, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'd2, 1'b1);
        check("g_load2", 8'h04, 3'd2, 1'b0, 1'b0);
`endif

        // Asynchronous reset while scanning
        drive(1'b0, 1'b1, 3'd0, 1'b0);
        scan_run(3, "pre_rst");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 3'd0, 1'b0);
        check("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
